// File: rtl/wb_pkg.sv
// Shared types for the write-back commit queue: one queued result pair
// and the default queue depth.
package wb_pkg;

  localparam int WB_DEPTH  = 4;
  // Field widths of a stored entry; a queue instance must not exceed them.
  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef struct packed {
    logic [1:0]           en;
    logic [WB_ADDR_W-1:0] addrA;
    logic [WB_DATA_W-1:0] dataA;
    logic [WB_ADDR_W-1:0] addrB;
    logic [WB_DATA_W-1:0] dataB;
  } wb_entry_t;

endpackage

// File: rtl/wb_waw_filter.sv
// Enqueue-time write masking: register 0 is never written, and when both
// lanes target the same register the younger lane B wins.
module wb_waw_filter #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [1:0]            en,
  input  logic [ADDR_WIDTH-1:0] addrA,
  input  logic [ADDR_WIDTH-1:0] addrB,
  output logic [1:0]            en_masked
);

  always_comb begin
    en_masked = en;
    if (addrA == '0) en_masked[1] = 1'b0;
    if (addrB == '0) en_masked[0] = 1'b0;
    if (en_masked == 2'b11 && addrA == addrB) en_masked[1] = 1'b0;
  end

endmodule

// File: rtl/wb_commit_queue.sv
// In-order write-back commit queue: buffers dual-lane results and retires the
// oldest pair straight onto the register-file write port when commit is asserted.
module wb_commit_queue
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = WB_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_en,
  input  logic [ADDR_WIDTH-1:0]     in_addrA,
  input  logic [ADDR_WIDTH-1:0]     in_addrB,
  input  logic [DATA_WIDTH-1:0]     in_dataA,
  input  logic [DATA_WIDTH-1:0]     in_dataB,
  input  logic                      commit,
  input  logic                      flush,
  output logic [1:0]                write_enable,
  output logic [ADDR_WIDTH-1:0]     waddrA,
  output logic [ADDR_WIDTH-1:0]     waddrB,
  output logic [DATA_WIDTH-1:0]     wdataA,
  output logic [DATA_WIDTH-1:0]     wdataB,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      commit_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count_q;
  logic          err_q;
  logic [1:0]    en_masked;
  logic          do_enq, do_commit, full;
  wb_entry_t     mem [DEPTH];
  wb_entry_t     head_e, new_e;

  wb_waw_filter #(.ADDR_WIDTH(ADDR_WIDTH)) u_filter (
    .en        (in_en),
    .addrA     (in_addrA),
    .addrB     (in_addrB),
    .en_masked (en_masked)
  );

  // Handshake: a pair transfers on a rising edge where in_valid && in_ready
  // and no flush; in_ready depends only on registered occupancy (and reset),
  // never on commit or flush, so a full queue stalls one cycle even if draining.
  assign full      = (count_q == CW'(DEPTH));
  assign in_ready  = !reset && !full;
  assign do_enq    = in_valid && in_ready && !flush;
  assign do_commit = commit && (count_q != '0);

  always_comb begin
    new_e       = '0;
    new_e.en    = en_masked;
    new_e.addrA = WB_ADDR_W'(in_addrA);
    new_e.dataA = WB_DATA_W'(in_dataA);
    new_e.addrB = WB_ADDR_W'(in_addrB);
    new_e.dataB = WB_DATA_W'(in_dataB);
  end

  assign head_e       = mem[head];
  assign write_enable = do_commit ? head_e.en : 2'b00;
  assign waddrA       = ADDR_WIDTH'(head_e.addrA);
  assign waddrB       = ADDR_WIDTH'(head_e.addrB);
  assign wdataA       = DATA_WIDTH'(head_e.dataA);
  assign wdataB       = DATA_WIDTH'(head_e.dataB);
  assign count        = count_q;
  assign commit_err   = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (do_commit) head <= head + PW'(1);
      if (commit && count_q == '0) err_q <= 1'b1;
      if (flush) begin
        // The committing head (if any) still retires; everything behind it is dropped.
        tail    <= do_commit ? head + PW'(1) : head;
        count_q <= '0;
      end else begin
        if (do_enq) tail <= tail + PW'(1);
        case ({do_enq, do_commit})
          2'b10:   count_q <= count_q + CW'(1);
          2'b01:   count_q <= count_q - CW'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Entry payloads are not reset; occupancy alone says which are live.
  always_ff @(posedge clk) begin
    if (do_enq) mem[tail] <= new_e;
  end

endmodule

// File: tb/tb_wb_commit_queue.sv
// Bench for wb_commit_queue: directed cases plus randomized traffic checked
// every cycle against a queue-based model of the commit semantics.
module tb_wb_commit_queue;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int EW    = 2 + 2 * (AW + DW);

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_en;
  logic [AW-1:0] in_addrA, in_addrB;
  logic [DW-1:0] in_dataA, in_dataB;
  logic          commit, flush;
  logic [1:0]    write_enable;
  logic [AW-1:0] waddrA, waddrB;
  logic [DW-1:0] wdataA, wdataB;
  logic [CW-1:0] count;
  logic          commit_err;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];
  logic          exp_err = 1'b0;
  logic [EW-1:0] head_m;
  logic [EW-1:0] pin_e;
  int            n_m;

  wb_commit_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_en        (in_en),
    .in_addrA     (in_addrA),
    .in_addrB     (in_addrB),
    .in_dataA     (in_dataA),
    .in_dataB     (in_dataB),
    .commit       (commit),
    .flush        (flush),
    .write_enable (write_enable),
    .waddrA       (waddrA),
    .waddrB       (waddrB),
    .wdataA       (wdataA),
    .wdataB       (wdataB),
    .count        (count),
    .commit_err   (commit_err)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Which lanes actually reach the register file, stated from the write rules.
  function automatic logic [EW-1:0] model_entry(logic [1:0] en, logic [AW-1:0] aA,
      logic [DW-1:0] dA, logic [AW-1:0] aB, logic [DW-1:0] dB);
    logic wa, wb;
    wb = en[0] && (aB != 0);
    wa = en[1] && (aA != 0) && !(en[0] && aA == aB);
    return {wa, wb, aA, dA, aB, dB};
  endfunction

  // Reference model update
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      exp_err = 1'b0;
    end else begin
      n_m = exp_q.size();
      if (commit && n_m == 0) exp_err = 1'b1;
      if (commit && n_m > 0) void'(exp_q.pop_front());
      if (flush) exp_q.delete();
      else if (in_valid && n_m < DEPTH)
        exp_q.push_back(model_entry(in_en, in_addrA, in_dataA, in_addrB, in_dataB));
    end
  end

  // Compare process: every cycle, mid-low-phase after inputs settle
  always @(negedge clk) begin
    #2;
    check("in_ready", in_ready, (!reset && exp_q.size() < DEPTH));
    check("count", count, exp_q.size());
    check("commit_err", commit_err, exp_err);
    if (!reset && commit && exp_q.size() > 0) begin
      head_m = exp_q[0];
      check("write_enable", write_enable, head_m[EW-1 -: 2]);
      if (head_m[EW-1]) begin
        check("waddrA", waddrA, head_m[EW-3 -: AW]);
        check("wdataA", wdataA, head_m[2*DW+AW-1 -: DW]);
      end
      if (head_m[EW-2]) begin
        check("waddrB", waddrB, head_m[DW+AW-1 -: AW]);
        check("wdataB", wdataB, head_m[DW-1:0]);
      end
    end else begin
      check("write_enable_idle", write_enable, 2'b00);
    end
  end

  // Driver tasks
  task automatic drive(input logic v, input logic [1:0] en, input logic [AW-1:0] aA,
      input logic [DW-1:0] dA, input logic [AW-1:0] aB, input logic [DW-1:0] dB,
      input logic c, input logic f);
    @(negedge clk);
    in_valid = v; in_en = en; in_addrA = aA; in_dataA = dA;
    in_addrB = aB; in_dataB = dB; commit = c; flush = f;
    #3;
  endtask

  task automatic idle();
    drive(1'b0, 2'b00, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic enq(input logic [1:0] en, input logic [AW-1:0] aA, input logic [DW-1:0] dA,
      input logic [AW-1:0] aB, input logic [DW-1:0] dB);
    drive(1'b1, en, aA, dA, aB, dB, 1'b0, 1'b0);
  endtask

  task automatic do_commit_only(input logic f);
    drive(1'b0, 2'b00, '0, '0, '0, '0, 1'b1, f);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_en = '0; in_addrA = '0; in_addrB = '0;
    in_dataA = '0; in_dataB = '0; commit = 1'b0; flush = 1'b0;

    // Pin the model's masking rules with hand-derived values
    pin_e = model_entry(2'b11, 5'd7, 32'd1, 5'd7, 32'd2);
    check("model_waw", pin_e[EW-1 -: 2], 2'b01);
    pin_e = model_entry(2'b11, 5'd0, 32'd1, 5'd3, 32'd2);
    check("model_addr0", pin_e[EW-1 -: 2], 2'b01);

    repeat (3) @(negedge clk);
    #3;
    check("reset_in_ready", in_ready, 1'b0);
    check("reset_count", count, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("ready_after_reset", in_ready, 1'b1);

    // Basic enqueue then commit
    enq(2'b11, 5'd5, 32'hAAAA, 5'd6, 32'hBBBB);
    do_commit_only(1'b0);
    check("basic_we", write_enable, 2'b11);
    check("basic_waddrA", waddrA, 5);
    check("basic_wdataA", wdataA, 32'hAAAA);
    check("basic_waddrB", waddrB, 6);
    check("basic_wdataB", wdataB, 32'hBBBB);
    check("basic_count_before", count, 1);
    idle();
    check("basic_count_after", count, 0);

    // Write-after-write: lane B wins
    enq(2'b11, 5'd7, 32'd1, 5'd7, 32'd2);
    do_commit_only(1'b0);
    check("waw_we", write_enable, 2'b01);
    check("waw_waddrB", waddrB, 7);
    check("waw_wdataB", wdataB, 2);

    // Address zero: bubble still retires
    enq(2'b10, 5'd0, 32'hFFFF, 5'd3, 32'd0);
    do_commit_only(1'b0);
    check("addr0_we", write_enable, 2'b00);
    check("addr0_count_before", count, 1);
    idle();
    check("addr0_count_after", count, 0);

    // Full queue holds off an offer even with commit
    for (int i = 0; i < DEPTH; i++)
      enq(2'b11, AW'(i + 1), DW'(i + 100), AW'(i + 9), DW'(i + 200));
    idle();
    check("full_ready", in_ready, 1'b0);
    check("full_count", count, 4);
    drive(1'b1, 2'b11, 5'd20, 32'd55, 5'd21, 32'd66, 1'b1, 1'b0);
    check("full_commit_ready", in_ready, 1'b0);
    check("full_commit_waddrA", waddrA, 1);
    idle();
    check("full_drain_count", count, 3);
    check("full_drain_ready", in_ready, 1'b1);

    // Commit together with flush
    do_commit_only(1'b1);
    check("cf_we", write_enable, 2'b11);
    check("cf_waddrA", waddrA, 2);
    check("cf_wdataB", wdataB, 201);
    idle();
    check("cf_count", count, 0);
    do_commit_only(1'b0);
    check("empty_commit_we", write_enable, 2'b00);
    idle();
    check("empty_commit_err", commit_err, 1'b1);

    // Asynchronous reset mid-operation
    enq(2'b01, 5'd0, 32'd0, 5'd4, 32'd44);
    enq(2'b10, 5'd8, 32'd88, 5'd0, 32'd0);
    idle();
    check("pre_reset_count", count, 2);
    @(negedge clk);
    commit = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("mid_reset_count", count, 0);
    check("mid_reset_we", write_enable, 2'b00);
    check("mid_reset_err", commit_err, 1'b0);
    check("mid_reset_ready", in_ready, 1'b0);
    @(negedge clk);
    commit = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            AW'($urandom_range(0, 3)), $urandom(),
            AW'($urandom_range(0, 3)), $urandom(),
            ($urandom_range(0, 99) < 40), ($urandom_range(0, 15) == 0));
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
